// File: rtl/ct_pkg.sv
// Shared CT definitions: word width, frame size and fill-state encoding.
// Used by the CT controller and the result collector.
package ct_pkg;

  localparam int CT_DW     = 8;
  localparam int CT_NWORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } fill_st_t;

endpackage

// File: rtl/ct_result_collector_if.sv
// Result handshake bundle: frame words plus valid/ready.
// The collector is the master, the display/readout sink is the slave.
interface ct_result_collector_if #(
  parameter int DW = ct_pkg::CT_DW
);

  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] c_1_1;
  logic [DW-1:0] c_1_2;
  logic [DW-1:0] c_2_1;
  logic [DW-1:0] c_2_2;

  modport master (
    output res_valid,
    output c_1_1,
    output c_1_2,
    output c_2_1,
    output c_2_2,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  c_1_1,
    input  c_1_2,
    input  c_2_1,
    input  c_2_2,
    output res_ready
  );

endinterface

// File: rtl/ct_out_bank.sv
// Output bank of the result collector: holds one complete frame
// and runs the res_valid/res_ready handshake toward the sink.
module ct_out_bank
  import ct_pkg::*;
#(
  parameter int DW     = CT_DW,
  parameter int NWORDS = CT_NWORDS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [NWORDS-1:0][DW-1:0]    fill,
  output logic                         free,
  output logic                         xfer,
  ct_result_collector_if.master        res
);

  logic                      valid_q;
  logic [NWORDS-1:0][DW-1:0] bank_q;

  assign xfer = valid_q & res.res_ready;
  assign free = !valid_q | res.res_ready;

  // Load a new frame when free; otherwise drop valid after handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      bank_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      bank_q  <= fill;
    end else if (xfer) begin
      valid_q <= 1'b0;
    end
  end

  assign res.res_valid = valid_q;
  assign res.c_1_1     = bank_q[0];
  assign res.c_1_2     = bank_q[1];
  assign res.c_2_1     = bank_q[2];
  assign res.c_2_2     = bank_q[3];

endmodule

// File: rtl/ct_result_collector.sv
// Collects serial CT result words into frames and double-buffers them.
// Optional frame counter output enabled by `CT_FRAME_CNT_EN.
module ct_result_collector
  import ct_pkg::*;
#(
  parameter int DW     = CT_DW,
  parameter int NWORDS = CT_NWORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ct_en_result,
  input  logic [DW-1:0]         ct_result,
  input  logic                  ct_done,
  ct_result_collector_if.master res,
  output logic                  busy,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  overflow
`ifdef CT_FRAME_CNT_EN
  ,
  output logic [7:0]            frame_cnt
`endif
);

  localparam int CW = $clog2(NWORDS + 1);

  fill_st_t                  state;
  fill_st_t                  state_nx;
  logic [CW-1:0]             cnt;
  logic [CW-1:0]             cnt_nx;
  logic [CW-1:0]             wr_idx;
  logic                      wr_en;
  logic                      load;
  logic                      free;
  logic                      xfer;
  logic                      set_short;
  logic                      set_long;
  logic                      set_ovf;
  logic [NWORDS-1:0][DW-1:0] fill;

  // Fill-state register and word count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next state: capture first, then judge ct_done on the new count.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wr_en     = 1'b0;
    wr_idx    = cnt;
    load      = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    set_ovf   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ct_en_result) begin
          wr_en    = 1'b1;
          wr_idx   = '0;
          cnt_nx   = CW'(1);
          state_nx = ST_FILL;
        end
      end
      ST_FILL: begin
        if (ct_en_result) begin
          if (cnt < CW'(NWORDS)) begin
            wr_en  = 1'b1;
            cnt_nx = cnt + CW'(1);
          end else begin
            set_long = 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (free) begin
          load     = 1'b1;
          cnt_nx   = '0;
          state_nx = ST_IDLE;
          if (ct_en_result) begin
            wr_en    = 1'b1;
            wr_idx   = '0;
            cnt_nx   = CW'(1);
            state_nx = ST_FILL;
          end
        end else if (ct_en_result) begin
          set_ovf = 1'b1;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = ST_IDLE;
      end
    endcase
    if (ct_done && state_nx == ST_FILL) begin
      if (cnt_nx == CW'(NWORDS)) begin
        state_nx = ST_FULL;
      end else begin
        set_short = 1'b1;
        cnt_nx    = '0;
        state_nx  = ST_IDLE;
      end
    end
  end

  // Fill buffer write at the selected word slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (CW'(i) == wr_idx) fill[i] <= ct_result;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (set_short) err_short <= 1'b1;
      if (set_long)  err_long  <= 1'b1;
      if (set_ovf)   overflow  <= 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);

  ct_out_bank #(
    .DW     (DW),
    .NWORDS (NWORDS)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .fill  (fill),
    .free  (free),
    .xfer  (xfer),
    .res   (res)
  );

`ifdef CT_FRAME_CNT_EN
  // Count handshaked frames, wrapping at 8 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= 8'd0;
    end else if (xfer) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ct_result_collector.sv
// Directed bench for ct_result_collector.
// Build with +define+CT_FRAME_CNT_EN to also cover the frame counter.
module tb_ct_result_collector;

  logic       clk;
  logic       reset;
  logic       ct_en_result;
  logic [7:0] ct_result;
  logic       ct_done;
  logic       busy;
  logic       err_short;
  logic       err_long;
  logic       overflow;
`ifdef CT_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  int total = 0;
  int bad   = 0;

  ct_result_collector_if #(.DW(8)) res_if ();

  ct_result_collector dut (
    .clk          (clk),
    .reset        (reset),
    .ct_en_result (ct_en_result),
    .ct_result    (ct_result),
    .ct_done      (ct_done),
    .res          (res_if.master),
    .busy         (busy),
    .err_short    (err_short),
    .err_long     (err_long),
    .overflow     (overflow)
`ifdef CT_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic en, input logic [7:0] d,
                       input logic dn);
    @(negedge clk);
    ct_en_result = en;
    ct_result    = d;
    ct_done      = dn;
  endtask

  task automatic test_reset;
    reset        = 1'b0;
    ct_en_result = 1'b0;
    ct_result    = 8'h00;
    ct_done      = 1'b0;
    res_if.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({res_if.res_valid, busy, err_short, err_long, overflow} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=00000",
               {res_if.res_valid, busy, err_short, err_long, overflow});
    end
    total++;
    if ({res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2} !== 32'h0) begin
      bad++;
      $display("FAIL reset_c got=%h exp=0",
               {res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2});
    end
    reset = 1'b1;
  endtask

  task automatic test_single;
    drive(1, 8'h11, 0);
    drive(1, 8'h22, 0);
    drive(1, 8'h33, 0);
    drive(1, 8'h44, 1);
    drive(0, 8'h00, 0);
    total++;
    if (res_if.res_valid !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_lat1 valid=%b busy=%b exp valid=0 busy=1",
               res_if.res_valid, busy);
    end
    drive(0, 8'h00, 0);
    total++;
    if (res_if.res_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_valid got=%b exp=1", res_if.res_valid);
    end
    total++;
    if ({res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2}
        !== 32'h11223344) begin
      bad++;
      $display("FAIL single_data got=%h exp=11223344",
               {res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2});
    end
    drive(0, 8'h00, 0);
    total++;
    if (res_if.res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_drop valid=%b busy=%b exp 0 0",
               res_if.res_valid, busy);
    end
  endtask

  task automatic test_back_to_back;
    res_if.res_ready = 1'b0;
    drive(1, 8'h51, 0);
    drive(1, 8'h52, 0);
    drive(1, 8'h53, 0);
    drive(1, 8'h54, 1);
    drive(0, 8'h00, 0);
    drive(0, 8'h00, 0);
    drive(1, 8'h61, 0);
    drive(1, 8'h62, 0);
    drive(1, 8'h63, 0);
    drive(1, 8'h64, 1);
    drive(0, 8'h00, 0);
    total++;
    if (res_if.res_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_hold valid=%b busy=%b exp 1 1",
               res_if.res_valid, busy);
    end
    drive(1, 8'h71, 0);
    drive(0, 8'h00, 0);
    total++;
    if (overflow !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_overflow ovf=%b busy=%b exp 1 1", overflow, busy);
    end
    total++;
    if ({res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2}
        !== 32'h51525354) begin
      bad++;
      $display("FAIL b2b_frame1 got=%h exp=51525354",
               {res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2});
    end
    res_if.res_ready = 1'b1;
    drive(0, 8'h00, 0);
    total++;
    if (res_if.res_valid !== 1'b1 ||
        {res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2}
        !== 32'h61626364) begin
      bad++;
      $display("FAIL b2b_frame2 valid=%b data=%h exp 1 61626364",
               res_if.res_valid,
               {res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2});
    end
    drive(0, 8'h00, 0);
    total++;
    if (res_if.res_valid !== 1'b0 || busy !== 1'b0 || err_short !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end valid=%b busy=%b short=%b exp 0 0 0",
               res_if.res_valid, busy, err_short);
    end
  endtask

  task automatic test_short;
    drive(1, 8'h01, 0);
    drive(1, 8'h02, 0);
    drive(1, 8'h03, 1);
    drive(0, 8'h00, 0);
    total++;
    if (err_short !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL short_flag short=%b busy=%b exp 1 0", err_short, busy);
    end
    drive(0, 8'h00, 0);
    total++;
    if (res_if.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL short_novalid got=%b exp=0", res_if.res_valid);
    end
    drive(1, 8'h0A, 0);
    drive(1, 8'h0B, 0);
    drive(1, 8'h0C, 0);
    drive(1, 8'h0D, 1);
    drive(0, 8'h00, 0);
    drive(0, 8'h00, 0);
    total++;
    if (res_if.res_valid !== 1'b1 ||
        {res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2}
        !== 32'h0A0B0C0D) begin
      bad++;
      $display("FAIL short_next valid=%b data=%h exp 1 0a0b0c0d",
               res_if.res_valid,
               {res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2});
    end
    drive(0, 8'h00, 0);
  endtask

  task automatic test_long;
    total++;
    if (err_long !== 1'b0) begin
      bad++;
      $display("FAIL long_pre got=%b exp=0", err_long);
    end
    drive(1, 8'hB1, 0);
    drive(1, 8'hB2, 0);
    drive(1, 8'hB3, 0);
    drive(1, 8'hB4, 0);
    drive(1, 8'hB5, 0);
    drive(0, 8'h00, 1);
    drive(0, 8'h00, 0);
    total++;
    if (err_long !== 1'b1 || res_if.res_valid !== 1'b0) begin
      bad++;
      $display("FAIL long_flag long=%b valid=%b exp 1 0",
               err_long, res_if.res_valid);
    end
    drive(0, 8'h00, 0);
    total++;
    if (res_if.res_valid !== 1'b1 ||
        {res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2}
        !== 32'hB1B2B3B4) begin
      bad++;
      $display("FAIL long_data valid=%b data=%h exp 1 b1b2b3b4",
               res_if.res_valid,
               {res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2});
    end
    drive(0, 8'h00, 0);
  endtask

  task automatic test_async_reset;
    drive(1, 8'hC1, 0);
    drive(1, 8'hC2, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({res_if.res_valid, busy, err_short, err_long, overflow} !== 5'b0) begin
      bad++;
      $display("FAIL areset_flags got=%b exp=00000",
               {res_if.res_valid, busy, err_short, err_long, overflow});
    end
    total++;
    if ({res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2} !== 32'h0) begin
      bad++;
      $display("FAIL areset_c got=%h exp=0",
               {res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2});
    end
    drive(0, 8'h00, 0);
    reset = 1'b1;
    drive(1, 8'hA0, 0);
    drive(1, 8'hA1, 0);
    drive(1, 8'hA2, 0);
    drive(1, 8'hA3, 1);
    drive(0, 8'h00, 0);
    drive(0, 8'h00, 0);
    total++;
    if (res_if.res_valid !== 1'b1 ||
        {res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2}
        !== 32'hA0A1A2A3) begin
      bad++;
      $display("FAIL areset_frame valid=%b data=%h exp 1 a0a1a2a3",
               res_if.res_valid,
               {res_if.c_1_1, res_if.c_1_2, res_if.c_2_1, res_if.c_2_2});
    end
    drive(0, 8'h00, 0);
  endtask

`ifdef CT_FRAME_CNT_EN
  task automatic test_frame_cnt;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    total++;
    if (frame_cnt !== 8'd0) begin
      bad++;
      $display("FAIL fcnt_reset got=%0d exp=0", frame_cnt);
    end
    for (int f = 0; f < 257; f++) begin
      drive(1, 8'(f), 0);
      drive(1, 8'h01, 0);
      drive(1, 8'h02, 0);
      drive(1, 8'h03, 1);
      drive(0, 8'h00, 0);
      drive(0, 8'h00, 0);
      drive(0, 8'h00, 0);
      if (f == 255) begin
        total++;
        if (frame_cnt !== 8'd0) begin
          bad++;
          $display("FAIL fcnt_wrap got=%0d exp=0", frame_cnt);
        end
      end
    end
    total++;
    if (frame_cnt !== 8'd1) begin
      bad++;
      $display("FAIL fcnt_257 got=%0d exp=1", frame_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_short();
    test_long();
    test_async_reset();
`ifdef CT_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
